mips_fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the R-type decode controller. Holds the PC, issues single-outstanding

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_pc_gen.sv | 38 +++
 rtl/mips_fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_mips_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [5:0]  FUNCT_JR         = 6'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_pc_gen.sv
// Program counter: sequential +4 advance (32-bit wrap) or word-aligned redirect.
module mips_pc_gen
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;

    // Redirect wins over increment; the target's low bits are dropped.
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = word_align(target);
        end else if (inc) begin
            pc_next = pc_reg + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= word_align(RESET_PC);
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem reads, one-word skid, JR redirect.
// FETCH_DELAY_SLOT_EN: deliver the sequential word after a JR instead of squashing it.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump_register,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  pc_out_reg, pc_out_next;
    logic         valid_reg, valid_next;
    logic [31:0]  skid_reg, skid_next;
    logic [31:0]  skid_pc_reg, skid_pc_next;
    logic [31:0]  tgt_reg, tgt_next;
`ifdef FETCH_DELAY_SLOT_EN
    logic         pend_reg, pend_next;
`endif

    logic        pc_inc;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] pc;
    logic        jr_fire;
    logic [31:0] jr_aligned;

    assign jr_fire    = jump_register & valid_reg & ~stall;
    assign jr_aligned = word_align(jr_target);

    mips_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .redirect (pc_redirect),
        .target   (pc_target),
        .pc       (pc)
    );

    always_comb begin
        state_next   = state_reg;
        instr_next   = instr_reg;
        pc_out_next  = pc_out_reg;
        valid_next   = valid_reg;
        skid_next    = skid_reg;
        skid_pc_next = skid_pc_reg;
        tgt_next     = tgt_reg;
`ifdef FETCH_DELAY_SLOT_EN
        pend_next    = pend_reg;
`endif
        pc_inc       = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = jr_aligned;
        imem_req     = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
`ifdef FETCH_DELAY_SLOT_EN
                    if (stall) begin
                        skid_next    = imem_rdata;
                        skid_pc_next = pc;
                        state_next   = HOLD;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                        valid_next  = 1'b1;
                    end
                    pend_next = 1'b0;
                    if (jr_fire) begin
                        pc_redirect = 1'b1;
                    end else if (pend_reg) begin
                        pc_redirect = 1'b1;
                        pc_target   = tgt_reg;
                    end else begin
                        pc_inc = 1'b1;
                    end
`else
                    if (jr_fire) begin
                        // Returning word is the sequential one after JR: drop it.
                        instr_next  = NOP_WORD;
                        valid_next  = 1'b0;
                        pc_redirect = 1'b1;
                    end else if (stall) begin
                        skid_next    = imem_rdata;
                        skid_pc_next = pc;
                        pc_inc       = 1'b1;
                        state_next   = HOLD;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc;
                        valid_next  = 1'b1;
                        pc_inc      = 1'b1;
                    end
`endif
                end else if (jr_fire) begin
                    // imem_addr must stay put while the request is open, so the
                    // redirect is parked in tgt_reg until the response arrives.
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                    tgt_next   = jr_aligned;
`ifdef FETCH_DELAY_SLOT_EN
                    pend_next  = 1'b1;
`else
                    state_next = SQUASH;
`endif
                end else if (!stall) begin
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_next = FETCH;
                    if (jr_fire) begin
                        pc_redirect = 1'b1;
                    end
`ifdef FETCH_DELAY_SLOT_EN
                    instr_next  = skid_reg;
                    pc_out_next = skid_pc_reg;
                    valid_next  = 1'b1;
`else
                    if (jr_fire) begin
                        instr_next = NOP_WORD;
                        valid_next = 1'b0;
                    end else begin
                        instr_next  = skid_reg;
                        pc_out_next = skid_pc_reg;
                        valid_next  = 1'b1;
                    end
`endif
                end
            end
            SQUASH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    pc_redirect = 1'b1;
                    pc_target   = tgt_reg;
                    state_next  = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            instr_reg   <= NOP_WORD;
            pc_out_reg  <= RESET_PC;
            valid_reg   <= 1'b0;
            skid_reg    <= NOP_WORD;
            skid_pc_reg <= RESET_PC;
            tgt_reg     <= RESET_PC;
`ifdef FETCH_DELAY_SLOT_EN
            pend_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            instr_reg   <= instr_next;
            pc_out_reg  <= pc_out_next;
            valid_reg   <= valid_next;
            skid_reg    <= skid_next;
            skid_pc_reg <= skid_pc_next;
            tgt_reg     <= tgt_next;
`ifdef FETCH_DELAY_SLOT_EN
            pend_reg    <= pend_next;
`endif
        end
    end

    assign imem_addr   = pc;
    assign instruction = instr_reg;
    assign pc_out      = pc_out_reg;
    assign instr_valid = valid_reg;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a behavioural variable-latency imem.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jump_register;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;

    int errors = 0;
    int checks = 0;

    int lat = 0;
    int wait_cnt = 0;
    bit word_mode = 1'b0;
    bit force_valid = 1'b0;

    mips_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .jump_register (jump_register),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return word_mode ? (a ^ 32'hC0DE_0000) : 32'h0109_5020;
    endfunction

    // imem: answers after 'lat' idle cycles of an open request.
    always @(negedge clk) begin
        if (force_valid) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end else if (imem_req) begin
            if (wait_cnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = word_at(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_valid = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            imem_valid = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] seen [2];
        int   nseen;
        bit   found;

        rst_n = 1'b0; stall = 1'b0; jump_register = 1'b0; jr_target = 32'h0;
        tick(); tick();
        check("rst_req",   imem_req,    0);
        check("rst_addr",  imem_addr,   32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pcout", pc_out,      32'h0);
        check("rst_valid", instr_valid, 0);

        // 1: zero-wait imem
        rst_n = 1'b1;
        tick();
        check("t1_req_c1",  imem_req,  1);
        check("t1_addr_c1", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_valid", instr_valid, 1);
            check("t1_pcout", pc_out,      32'(4 * i));
            check("t1_instr", instruction, 32'h0109_5020);
        end

        // 2: three wait cycles on the request at 0xC
        lat = 3; word_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_addr_hold", imem_addr,   32'hC);
            check("t2_bubble_v",  instr_valid, 0);
            check("t2_bubble_w",  instruction, 32'h0);
        end
        tick();
        check("t2_valid", instr_valid, 1);
        check("t2_pcout", pc_out,      32'hC);
        check("t2_instr", instruction, 32'hC0DE_000C);

        // 3: stall while the word at 0x10 lands
        lat = 0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold_req",   imem_req,    0);
            check("t3_hold_pcout", pc_out,      32'hC);
            check("t3_hold_valid", instr_valid, 1);
            check("t3_hold_instr", instruction, 32'hC0DE_000C);
        end
        stall = 1'b0;
        tick();
        check("t3_skid_pcout", pc_out,      32'h10);
        check("t3_skid_instr", instruction, 32'hC0DE_0010);
        check("t3_skid_valid", instr_valid, 1);
        check("t3_next_addr",  imem_addr,   32'h14);
        tick();
        check("t3_after_pcout", pc_out,      32'h14);
        check("t3_after_valid", instr_valid, 1);

        // 5: async reset while waiting on 0x20
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req && imem_addr == 32'h20) found = 1'b1;
            else tick();
        end
        check("t5_reach_0x20", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_req",   imem_req,    0);
        check("t5_async_valid", instr_valid, 0);
        check("t5_async_pcout", pc_out,      32'h0);
        check("t5_async_instr", instruction, 32'h0);
        check("t5_async_addr",  imem_addr,   32'h0);
        force_valid = 1'b1;
        tick();
        check("t5_stray_valid", instr_valid, 0);
        lat = 0;
        rst_n = 1'b1;
        tick();
        check("t5_rel_req",   imem_req,    1);
        check("t5_rel_addr",  imem_addr,   32'h0);
        check("t5_rel_valid", instr_valid, 0);
        force_valid = 1'b0;
        tick();
        check("t5_first_valid", instr_valid, 1);
        check("t5_first_pcout", pc_out,      32'h0);
        check("t5_first_instr", instruction, 32'hC0DE_0000);

        // 4: JR at 0x10 with the 0x14 fetch in flight
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid && pc_out == 32'h10) found = 1'b1;
            else tick();
        end
        check("t4_reach_0x10", found, 1);
        jump_register = 1'b1; jr_target = 32'h0000_0043;
        tick();
        jump_register = 1'b0; jr_target = 32'h0;
        check("t4_jr_bubble", instr_valid, 0);
        check("t4_jr_req",    imem_req,    1);
        check("t4_jr_addr",   imem_addr,   32'h14);
        nseen = 0;
        for (int i = 0; i < 12 && nseen < 2; i++) begin
            tick();
            if (instr_valid) begin
                seen[nseen] = pc_out;
                nseen++;
            end
        end
        check("t4_nseen", nseen, 2);
`ifdef FETCH_DELAY_SLOT_EN
        check("t4_first_pc",  seen[0], 32'h14);
        check("t4_second_pc", seen[1], 32'h40);
`else
        check("t4_first_pc",  seen[0], 32'h40);
        check("t4_second_pc", seen[1], 32'h44);
`endif

        // 6: JR to the top word, then wrap to 0
        jump_register = 1'b1; jr_target = 32'hFFFF_FFFF;
        tick();
        jump_register = 1'b0; jr_target = 32'h0;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (instr_valid && pc_out == 32'hFFFF_FFFC) found = 1'b1;
        end
        check("t6_reach_top", found, 1);
        check("t6_top_instr", instruction, 32'h3F21_FFFC);
        check("t6_wrap_addr", imem_addr,   32'h0);
        check("t6_wrap_req",  imem_req,    1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        check("t6_wrap_found", found,  1);
        check("t6_wrap_pcout", pc_out, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
